// File: rtl/mem_access_unit.sv
// RV32I load/store sequencer between a pipeline stage and a word-wide
// memory port: lane steering, sign extension and access fault detection.
module mem_access_unit #(
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_rd,
    output logic        rsp_load_regfile,
    output logic        rsp_fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        lrf_q, lrf_d;

    logic        req_undef;
    logic        req_misal;
    logic        req_fault;
    logic        in_access;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

    // Fault classification of the incoming request
    always_comb begin
        req_undef = 1'b0;
        if (req_is_store) begin
            req_undef = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            req_undef = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
        end
        req_misal = 1'b0;
        if (MISALIGN_CHECK) begin
            req_misal = ((req_funct3[1:0] == SZ_HALF) && req_addr[0])
                     || ((req_funct3[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00));
        end
        req_fault = req_undef || req_misal;
    end

    always_comb begin
        lane_b   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        load_ext = mem_rdata;
        unique case (1'b1)
            (f3_q[1:0] == SZ_BYTE): load_ext = {{24{~f3_q[2] & lane_b[7]}}, lane_b};
            (f3_q[1:0] == SZ_HALF): load_ext = {{16{~f3_q[2] & lane_h[15]}}, lane_h};
            default:                load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        lrf_d   = lrf_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d = req_is_store;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    rdata_d = '0;
                    lrf_d   = 1'b0;
                    fault_d = req_fault;
                    // Faulting requests never touch memory
                    state_d = req_fault ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (mem_resp) begin
                    rdata_d = store_q ? 32'd0 : load_ext;
                    lrf_d   = !store_q && (rd_q != 5'd0);
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            lrf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            lrf_q   <= lrf_d;
        end
    end

    assign in_access   = (state_q == ACCESS);
    assign req_ready   = (state_q == IDLE);
    assign mem_read    = in_access && !store_q;
    assign mem_write   = in_access && store_q;
    assign mem_address = in_access ? {addr_q[31:2], 2'b00} : 32'd0;

    // Store data is replicated so every enabled lane sees the right bytes
    always_comb begin
        mem_byte_enable = 4'b0000;
        mem_wdata       = 32'd0;
        if (in_access) begin
            if (!store_q) begin
                mem_byte_enable = 4'b1111;
            end else begin
                unique case (1'b1)
                    (f3_q[1:0] == SZ_BYTE): begin
                        mem_byte_enable = 4'b0001 << addr_q[1:0];
                        mem_wdata       = {4{wdata_q[7:0]}};
                    end
                    (f3_q[1:0] == SZ_HALF): begin
                        mem_byte_enable = 4'b0011 << addr_q[1:0];
                        mem_wdata       = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        mem_byte_enable = 4'b1111;
                        mem_wdata       = wdata_q;
                    end
                endcase
            end
        end
    end

    assign rsp_valid        = (state_q == RESP);
    assign rsp_rdata        = rsp_valid ? rdata_q : 32'd0;
    assign rsp_rd           = rsp_valid ? rd_q : 5'd0;
    assign rsp_fault        = rsp_valid && fault_q;
    assign rsp_load_regfile = rsp_valid && lrf_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset corner cases and
// randomized load/store traffic against a behavioural model.
module tb_mem_access_unit;

    localparam bit MIS = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_resp = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_load_regfile;
    logic        rsp_fault;

    always #5 clk = ~clk;

    mem_access_unit #(.MISALIGN_CHECK(MIS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_is_store(req_is_store),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_rd(req_rd),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata),
        .mem_resp(mem_resp),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_rd(rsp_rd),
        .rsp_load_regfile(rsp_load_regfile),
        .rsp_fault(rsp_fault)
    );

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          dly;
        int          hold;
    } txn_t;

    typedef struct {
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          fault;
        bit          lrf;
    } exp_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    string cur = "";

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s actual=%08h required=%08h", cur, nm, act, want);
        end
    endtask

    function automatic vec_t mk(bit st, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, logic [4:0] rd, logic [31:0] rdata,
                                int dly, int hold, logic [3:0] be, logic [31:0] ewd,
                                logic [31:0] erd, bit flt, bit lrf);
        vec_t v;
        v.t.st = st;   v.t.f3 = f3;     v.t.addr = addr;   v.t.wdata = wdata;
        v.t.rd = rd;   v.t.rdata = rdata; v.t.dly = dly;   v.t.hold = hold;
        v.e.be = be;   v.e.wdata = ewd; v.e.rdata = erd;   v.e.fault = flt;
        v.e.lrf = lrf;
        return v;
    endfunction

    // Reference: plain arithmetic on sizes, offsets and value ranges
    function automatic exp_t model(txn_t t);
        exp_t        e;
        int          sz;
        int          off;
        bit          legal;
        bit          mis;
        logic [31:0] v;
        sz  = int'(t.f3 % 3'd4);
        off = int'(t.addr % 32'd4);
        if (t.st) legal = (t.f3 <= 3'd2);
        else legal = (t.f3 == 3'd0) || (t.f3 == 3'd1) || (t.f3 == 3'd2)
                  || (t.f3 == 3'd4) || (t.f3 == 3'd5);
        mis = MIS && ((sz == 1 && off % 2 != 0) || (sz == 2 && off != 0));
        e.fault = !legal || mis;
        e.be = 4'd0;
        e.wdata = 32'd0;
        e.rdata = 32'd0;
        e.lrf = 1'b0;
        if (e.fault) return e;
        if (t.st) begin
            if (sz == 0) begin
                e.be = 4'(1 << off);
                e.wdata = (t.wdata & 32'hFF) * 32'h0101_0101;
            end else if (sz == 1) begin
                e.be = 4'((3 << off) & 15);
                e.wdata = (t.wdata & 32'hFFFF) * 32'h0001_0001;
            end else begin
                e.be = 4'hF;
                e.wdata = t.wdata;
            end
        end else begin
            e.be = 4'hF;
            if (sz == 0) begin
                v = (t.rdata >> (8 * off)) & 32'hFF;
                if (t.f3 < 3'd4 && v >= 32'd128) v = v - 32'd256;
            end else if (sz == 1) begin
                v = (t.rdata >> (16 * (off / 2))) & 32'hFFFF;
                if (t.f3 < 3'd4 && v >= 32'd32768) v = v - 32'd65536;
            end else begin
                v = t.rdata;
            end
            e.rdata = v;
            e.lrf = (t.rd != 5'd0);
        end
        return e;
    endfunction

    // Starts and ends on a falling edge with the unit idle
    task automatic run_txn(input string nm, input txn_t t, input exp_t e, input bit junk);
        cur = nm;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        chk("strobe_idle", {30'd0, mem_read, mem_write}, 32'd0);
        req_valid    = 1'b1;
        req_is_store = t.st;
        req_funct3   = t.f3;
        req_addr     = t.addr;
        req_wdata    = t.wdata;
        req_rd       = t.rd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (!e.fault) begin
            for (int c = 1; c <= t.dly; c++) begin
                chk("mem_read", {31'd0, mem_read}, {31'd0, !t.st});
                chk("mem_write", {31'd0, mem_write}, {31'd0, t.st});
                chk("mem_address", mem_address, t.addr & 32'hFFFF_FFFC);
                chk("byte_enable", {28'd0, mem_byte_enable}, {28'd0, e.be});
                if (t.st) chk("mem_wdata", mem_wdata, e.wdata);
                chk("rsp_valid_early", {31'd0, rsp_valid}, 32'd0);
                chk("req_ready_access", {31'd0, req_ready}, 32'd0);
                req_valid = junk;
                mem_resp  = (c == t.dly);
                mem_rdata = (c == t.dly) ? t.rdata : $urandom;
                @(negedge clk);
            end
            mem_resp  = 1'b0;
            req_valid = 1'b0;
        end
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("strobe_resp", {30'd0, mem_read, mem_write}, 32'd0);
        for (int h = 0; h <= t.hold; h++) begin
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_rd", {27'd0, rsp_rd}, {27'd0, t.rd});
            chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, e.fault});
            chk("rsp_load_regfile", {31'd0, rsp_load_regfile}, {31'd0, e.lrf});
            chk("rsp_valid_hold", {31'd0, rsp_valid}, 32'd1);
            chk("req_ready_resp", {31'd0, req_ready}, 32'd0);
            if (h == t.hold) begin
                rsp_ready = 1'b1;
                req_valid = 1'b0;
            end else if (junk) begin
                req_valid    = 1'b1;
                req_is_store = 1'($urandom);
                req_addr     = $urandom;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("rsp_valid_done", {31'd0, rsp_valid}, 32'd0);
    endtask

    vec_t        vecs[15];
    txn_t        t;
    exp_t        e;
    int unsigned lf[5] = '{0, 1, 2, 4, 5};

    initial begin
        vecs[0]  = mk(0, 3'd0, 32'h1003, 0, 5'd5, 32'h80FF_1234, 1, 0, 4'hF, 0, 32'hFFFF_FF80, 0, 1);
        vecs[1]  = mk(1, 3'd1, 32'h2002, 32'h0000_BEEF, 5'd0, 0, 3, 0, 4'hC, 32'hBEEF_BEEF, 0, 0, 0);
        vecs[2]  = mk(0, 3'd2, 32'h3001, 0, 5'd7, 32'h1111_1111, 1, 0, 4'h0, 0, 0, 1, 0);
        vecs[3]  = mk(0, 3'd5, 32'h4002, 0, 5'd0, 32'h9ABC_0000, 1, 0, 4'hF, 0, 32'h0000_9ABC, 0, 0);
        vecs[4]  = mk(0, 3'd1, 32'h5000, 0, 5'd3, 32'h1234_8001, 2, 5, 4'hF, 0, 32'hFFFF_8001, 0, 1);
        vecs[5]  = mk(1, 3'd0, 32'h6001, 32'h1234_56A5, 5'd2, 0, 2, 0, 4'h2, 32'hA5A5_A5A5, 0, 0, 0);
        vecs[6]  = mk(1, 3'd2, 32'h7000, 32'hDEAD_BEEF, 5'd4, 0, 1, 1, 4'hF, 32'hDEAD_BEEF, 0, 0, 0);
        vecs[7]  = mk(0, 3'd3, 32'h8000, 0, 5'd6, 32'h5555_5555, 1, 0, 4'h0, 0, 0, 1, 0);
        vecs[8]  = mk(1, 3'd5, 32'h8004, 32'h1, 5'd6, 0, 1, 0, 4'h0, 0, 0, 1, 0);
        vecs[9]  = mk(0, 3'd4, 32'h9001, 0, 5'd1, 32'h0000_8100, 1, 0, 4'hF, 0, 32'h0000_0081, 0, 1);
        vecs[10] = mk(1, 3'd1, 32'hA001, 32'h1234, 5'd0, 0, 1, 0, 4'h0, 0, 0, 1, 0);
        vecs[11] = mk(0, 3'd2, 32'hB004, 0, 5'd31, 32'hCAFE_F00D, 4, 0, 4'hF, 0, 32'hCAFE_F00D, 0, 1);
        vecs[12] = mk(0, 3'd0, 32'hC000, 0, 5'd8, 32'h0000_007F, 1, 0, 4'hF, 0, 32'h0000_007F, 0, 1);
        vecs[13] = mk(1, 3'd7, 32'hD000, 32'h9, 5'd9, 0, 1, 0, 4'h0, 0, 0, 1, 0);
        vecs[14] = mk(0, 3'd6, 32'hE000, 0, 5'd9, 32'h7, 1, 0, 4'h0, 0, 0, 1, 0);

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        cur = "reset";
        chk("req_ready", {31'd0, req_ready}, 32'd1);
        chk("strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rsp_flags", {29'd0, rsp_valid, rsp_fault, rsp_load_regfile}, 32'd0);
        chk("byte_enable", {28'd0, mem_byte_enable}, 32'd0);
        chk("mem_address", mem_address, 32'd0);
        chk("mem_wdata", mem_wdata, 32'd0);
        chk("rsp_rdata", rsp_rdata, 32'd0);
        chk("rsp_rd", {27'd0, rsp_rd}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First request lands in the very first cycle after release
        for (int i = 0; i < 15; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].t, vecs[i].e, vecs[i].t.hold > 0);
        end

        // Reset in the middle of a load
        cur = "midreset";
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2;
        req_addr = 32'h4000; req_rd = 5'd9;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mem_read_pre", {31'd0, mem_read}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mem_read_async", {31'd0, mem_read}, 32'd0);
        chk("mem_address_async", mem_address, 32'd0);
        chk("req_ready_async", {31'd0, req_ready}, 32'd1);
        chk("rsp_valid_async", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        mem_resp = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
        chk("strobe_after", {30'd0, mem_read, mem_write}, 32'd0);
        mem_resp = 1'b0;
        @(negedge clk);
        chk("rsp_valid_stray", {31'd0, rsp_valid}, 32'd0);
        run_txn("post_reset", vecs[0].t, vecs[0].e, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            t.st = 1'($urandom);
            if ($urandom_range(0, 3) == 0) t.f3 = 3'($urandom_range(0, 7));
            else if (t.st) t.f3 = 3'($urandom_range(0, 2));
            else t.f3 = 3'(lf[$urandom_range(0, 4)]);
            t.addr  = $urandom;
            t.wdata = $urandom;
            t.rd    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            t.rdata = $urandom;
            t.dly   = $urandom_range(1, 4);
            t.hold  = $urandom_range(0, 2);
            e = model(t);
            run_txn($sformatf("rnd%0d", n), t, e, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
